alu_scheduler: RTL and testbench
================================

ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 Parameter WIDTH, default 6, operand width in bits.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  2  per-requester request valid; bit i = requester i.
REQ-005 req_ready  output  2  per-requester accept strobe.
REQ-006 req_a  input  2*WIDTH  operand A; requester i in bits [i*WIDTH +: WIDTH].
REQ-007 req_b  input  2*WIDTH  operand B; same packing as req_a.
REQ-008 req_op  input  4  opcode, 2 bits per requester; 00 = add, 11 = multiply, 01/10 = illegal.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts result.
REQ-011 rsp_id  output  1  index of the requester that owns the result.
REQ-012 rsp_result  output  2*WIDTH  unsigned result, zero-extended.
REQ-013 rsp_err  output  1  set when the opcode was illegal.

Function
REQ-014 The FSM SHALL have the states IDLE, ADD, MUL and DONE, with one operation in flight at a time.
REQ-015 In IDLE, req_ready SHALL be one-hot on the arbitration winner and combinational from req_valid. In all other states req_ready SHALL be 0.
REQ-016 Arbitration SHALL be round-robin: a 1-bit pointer names the last-granted requester, and the other requester wins when both are valid. The pointer SHALL update only on accept.
REQ-017 Accept occurs at an edge where req_valid[i] & req_ready[i]. At that edge the block SHALL capture a, b, op and id.
REQ-018 Transitions from IDLE on accept (edge t):
  - op 00: go to ADD.
  - op 11: go to MUL.
  - illegal op: go directly to DONE.
REQ-019 ADD SHALL last 1 cycle, so rsp_valid rises at edge t+2. The result is a+b (WIDTH+1 significant bits).
REQ-020 MUL SHALL be shift-add over exactly WIDTH cycles, using a counter from 0 to WIDTH-1, so rsp_valid rises at edge t+WIDTH+1. The result is the full 2*WIDTH-bit product with no truncation.
REQ-021 An illegal op SHALL give rsp_valid at edge t+1 with rsp_result=0 and rsp_err=1. For legal ops rsp_err SHALL be 0.
REQ-022 In DONE, rsp_valid=1 and rsp_result, rsp_id and rsp_err SHALL stay stable until rsp_ready=1.
REQ-023 The result handshake edge SHALL return the FSM to IDLE. No new request is accepted in that same cycle, so there is a 1-cycle bubble minimum.
REQ-024 Requesters SHALL hold valid and operands until accepted. After capture, later operand changes SHALL NOT affect the result.
REQ-025 Extremes: all-ones operands SHALL NOT overflow the result. Zero operands SHALL still take the full latency.

Reset
REQ-026 Asserting rst_n=0 at any time, including mid-MUL or in DONE, SHALL immediately:
  - force the FSM to IDLE;
  - set the RR pointer to 1, so requester 0 wins first;
  - clear the counter and the operand/result registers;
  - drive rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0.
REQ-027 An operation in progress SHALL be discarded with no response.
REQ-028 The first accept SHALL be possible on the first edge after rst_n deasserts.

Structure
REQ-029 Package alu_sched_pkg SHALL hold:
  - the opcode constants OP_ADD=2'b00 and OP_MUL=2'b11;
  - the FSM state enum;
  - the default WIDTH.
REQ-030 The iterative multiplier SHALL be a sub-module, mul_shift_add, with these ports:
  - start, a, b (inputs);
  - busy, done, product (outputs).
  The arbiter, FSM and response register stay in alu_scheduler.

Verification (WIDTH=6)
REQ-031 req0 add with a=63, b=63 -> rsp_result=126, rsp_id=0, rsp_err=0, rsp_valid 2 cycles after accept.
REQ-032 req1 multiply with a=63, b=63 -> rsp_result=3969, rsp_id=1, rsp_valid 7 cycles after accept.
REQ-033 Both requesters valid continuously from reset with rsp_ready=1 -> grant order 0,1,0,1, and each accept is separated by the full latency plus 1 bubble.
REQ-034 req0 with op=01 -> rsp_valid 1 cycle after accept, rsp_err=1, rsp_result=0.
REQ-035 rsp_ready held low for 5 cycles in DONE -> outputs stable, req_ready=00. On release, the next accept occurs 1 cycle later.
REQ-036 rst_n pulsed low during MUL cycle 3 -> all outputs 0 at once. After release, req0 add 1+2 returns 3 with rsp_id=0.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared constants and types for the two-requester ALU scheduler.
// The opcode values, the FSM state encoding and the default operand width live here.
package alu_sched_pkg;

  localparam int DEFAULT_WIDTH = 6;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    MUL,
    DONE
  } state_t;

endpackage

// File: rtl/mul_shift_add.sv
// Iterative unsigned shift-add multiplier. It takes exactly WIDTH steps per operation.
// done is high during the final step, and product already includes that step's partial sum.
module mul_shift_add
  import alu_sched_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;

  // Partial sums never exceed the final product, so the 2*WIDTH accumulator cannot wrap.
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign done     = busy && (cnt == CNT_W'(WIDTH - 1));
  assign product  = acc_next;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (done) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_scheduler.sv
// Round-robin scheduler that lets two requesters share one add/multiply unit.
// It runs one operation at a time and holds a registered response until the consumer takes it.
module alu_scheduler
  import alu_sched_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [3:0]         req_op,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [2*WIDTH-1:0] rsp_result,
  output logic               rsp_err
);

  state_t             state;
  logic               rr_ptr;
  logic [WIDTH-1:0]   cap_a;
  logic [WIDTH-1:0]   cap_b;
  logic               cap_id;
  logic [1:0]         grant;
  logic               accept;
  logic               win_id;
  logic [1:0]         win_op;
  logic [WIDTH-1:0]   win_a;
  logic [WIDTH-1:0]   win_b;
  logic [WIDTH:0]     add_sum;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  // rr_ptr names the last winner; on contention the other requester is served.
  always_comb begin
    grant[0] = req_valid[0] & (~req_valid[1] | rr_ptr);
    grant[1] = req_valid[1] & (~req_valid[0] | ~rr_ptr);
  end

  assign req_ready = (state == IDLE && !mul_busy) ? grant : 2'b00;
  assign accept    = |req_ready;
  assign win_id    = req_ready[1];
  assign win_op    = win_id ? req_op[3:2] : req_op[1:0];
  assign win_a     = win_id ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
  assign win_b     = win_id ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
  assign mul_start = accept && (win_op == OP_MUL);
  assign add_sum   = {1'b0, cap_a} + {1'b0, cap_b};

  mul_shift_add #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (win_a),
    .b       (win_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= 1'b1;
      cap_a      <= '0;
      cap_b      <= '0;
      cap_id     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            cap_a  <= win_a;
            cap_b  <= win_b;
            cap_id <= win_id;
            rr_ptr <= win_id;
            if (win_op == OP_ADD) begin
              state <= ADD;
            end else if (win_op == OP_MUL) begin
              state <= MUL;
            end else begin
              // Illegal opcodes skip the datapath and answer with an error right away.
              rsp_valid  <= 1'b1;
              rsp_err    <= 1'b1;
              rsp_result <= '0;
              rsp_id     <= win_id;
              state      <= DONE;
            end
          end
        end
        ADD: begin
          rsp_valid  <= 1'b1;
          rsp_err    <= 1'b0;
          rsp_result <= (2*WIDTH)'(add_sum);
          rsp_id     <= cap_id;
          state      <= DONE;
        end
        MUL: begin
          if (mul_done) begin
            rsp_valid  <= 1'b1;
            rsp_err    <= 1'b0;
            rsp_result <= mul_product;
            rsp_id     <= cap_id;
            state      <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// Self-checking bench for alu_scheduler (WIDTH=6): directed vectors, multi-cycle corner sequences
// and a randomized run checked against a transaction-level reference model.
module tb_alu_scheduler;

  localparam int W = 6;

  logic           clk;
  logic           rst_n;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*W-1:0] req_a;
  logic [2*W-1:0] req_b;
  logic [3:0]     req_op;
  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_id;
  logic [2*W-1:0] rsp_result;
  logic           rsp_err;

  int n_tests = 0;
  int n_fail  = 0;

  alu_scheduler #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        id;
    logic [1:0]  op;
    logic [5:0]  a;
    logic [5:0]  b;
    logic [11:0] exp_res;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issues one request, waits for its grant, scrambles the operands after capture,
  // then measures latency (1 = response visible right after the accept edge).
  task automatic run_vec(input vec_t v);
    int         idx;
    int         lat;
    int         waited;
    logic [1:0] oh;
    idx = int'(v.id);
    oh  = 2'b01 << idx;
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = oh;
    req_a     = 12'($urandom);
    req_b     = 12'($urandom);
    req_op    = 4'($urandom);
    req_a[idx*W +: W] = v.a;
    req_b[idx*W +: W] = v.b;
    req_op[idx*2 +: 2] = v.op;
    #1;
    waited = 0;
    while (req_ready !== oh && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("vec_grant", req_ready, oh);
    if (req_ready !== oh) return;
    @(negedge clk);
    req_valid = 2'b00;
    req_a     = 12'($urandom);
    req_b     = 12'($urandom);
    req_op    = 4'($urandom);
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("vec_latency", lat, v.exp_lat);
    check("vec_result", rsp_result, v.exp_res);
    check("vec_id", rsp_id, v.id);
    check("vec_err", rsp_err, v.exp_err);
  endtask

  initial begin
    int         acc_cyc[4];
    logic       acc_id[4];
    int         n_acc;
    int         waited;
    logic [11:0] held;
    // Random-phase model state.
    bit         v[2];
    logic [5:0] ma[2];
    logic [5:0] mb[2];
    logic [1:0] mop[2];
    bit         m_ptr;
    bit         m_busy;
    int         m_due;
    bit         m_id;
    longint     m_res;
    bit         m_err;
    int         cyc;
    bit         exp_valid;
    logic [1:0] exp_rdy;
    int         lat;

    vecs[0] = '{1'b0, 2'b00, 6'd63, 6'd63, 12'd126,  1'b0, 2};
    vecs[1] = '{1'b1, 2'b11, 6'd63, 6'd63, 12'd3969, 1'b0, 7};
    vecs[2] = '{1'b0, 2'b01, 6'd12, 6'd34, 12'd0,    1'b1, 1};
    vecs[3] = '{1'b1, 2'b10, 6'd63, 6'd63, 12'd0,    1'b1, 1};
    vecs[4] = '{1'b0, 2'b11, 6'd0,  6'd0,  12'd0,    1'b0, 7};
    vecs[5] = '{1'b1, 2'b00, 6'd0,  6'd0,  12'd0,    1'b0, 2};
    vecs[6] = '{1'b0, 2'b11, 6'd63, 6'd1,  12'd63,   1'b0, 7};
    vecs[7] = '{1'b1, 2'b11, 6'd37, 6'd45, 12'd1665, 1'b0, 7};
    vecs[8] = '{1'b0, 2'b00, 6'd40, 6'd30, 12'd70,   1'b0, 2};
    vecs[9] = '{1'b1, 2'b11, 6'd1,  6'd63, 12'd63,   1'b0, 7};

    do_reset();
    #1;
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_id", rsp_id, 0);
    check("reset_rsp_result", rsp_result, 0);
    check("reset_rsp_err", rsp_err, 0);
    check("reset_req_ready", req_ready, 0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Both requesters valid from reset: grants alternate starting with 0, spaced by latency + bubble.
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_a     = {6'd5, 6'd4};
    req_b     = {6'd3, 6'd2};
    req_op    = 4'b0000;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_acc = 0;
    for (int k = 0; k < 40 && n_acc < 4; k++) begin
      #1;
      if (req_ready != 2'b00) begin
        acc_id[n_acc]  = req_ready[1];
        acc_cyc[n_acc] = k;
        n_acc++;
      end
      @(negedge clk);
    end
    check("rr_accepts", n_acc, 4);
    if (n_acc == 4) begin
      check("rr_first_cycle", acc_cyc[0], 0);
      for (int i = 0; i < 4; i++) check("rr_order", acc_id[i], i % 2);
      for (int i = 1; i < 4; i++) check("rr_spacing", acc_cyc[i] - acc_cyc[i-1], 3);
    end
    req_valid = 2'b00;
    repeat (4) @(negedge clk);

    // Backpressure in DONE: response held stable, no grants, then one bubble after release.
    req_valid = 2'b01;
    req_a     = {6'd7, 6'd10};
    req_b     = {6'd8, 6'd20};
    req_op    = 4'b0000;
    rsp_ready = 1'b0;
    #1;
    waited = 0;
    while (req_ready !== 2'b01 && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("bp_grant", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b10;
    waited = 0;
    while (rsp_valid !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("bp_rsp_valid", rsp_valid, 1);
    for (int j = 0; j < 5; j++) begin
      #1;
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_result", rsp_result, 30);
      check("bp_hold_id", rsp_id, 0);
      check("bp_hold_err", rsp_err, 0);
      check("bp_no_grant", req_ready, 2'b00);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_no_grant", req_ready, 2'b00);
    @(negedge clk);
    #1;
    check("bp_after_release_valid", rsp_valid, 0);
    check("bp_next_grant", req_ready, 2'b10);
    @(negedge clk);
    req_valid = 2'b00;
    waited = 0;
    while (rsp_valid !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("bp_second_result", rsp_result, 15);
    check("bp_second_id", rsp_id, 1);
    @(negedge clk);

    // Reset in the middle of a multiply: outputs clear at once and the multiply is dropped.
    req_valid = 2'b01;
    req_a     = {6'd0, 6'd63};
    req_b     = {6'd0, 6'd63};
    req_op    = 4'b0011;
    #1;
    waited = 0;
    while (req_ready !== 2'b01 && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("rst_mul_grant", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", rsp_valid, 0);
    check("rst_mid_id", rsp_id, 0);
    check("rst_mid_result", rsp_result, 0);
    check("rst_mid_err", rsp_err, 0);
    check("rst_mid_ready", req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid) lat++;
    end
    check("rst_discarded", lat, 0);
    run_vec('{1'b0, 2'b00, 6'd1, 6'd2, 12'd3, 1'b0, 2});

    // Randomized traffic against a transaction-level model.
    do_reset();
    m_ptr  = 1'b1;
    m_busy = 1'b0;
    m_due  = 0;
    m_id   = 1'b0;
    m_res  = 0;
    m_err  = 1'b0;
    cyc    = 0;
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; ma[i] = '0; mb[i] = '0; mop[i] = '0;
    end
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      cyc++;
      exp_valid = m_busy && (cyc >= m_due);
      check("rnd_rsp_valid", rsp_valid, exp_valid);
      if (exp_valid) begin
        check("rnd_rsp_id", rsp_id, m_id);
        check("rnd_rsp_result", rsp_result, m_res);
        check("rnd_rsp_err", rsp_err, m_err);
      end
      for (int i = 0; i < 2; i++) begin
        if (!v[i] && $urandom_range(0, 1) == 1) begin
          int r;
          v[i]  = 1'b1;
          ma[i] = 6'($urandom);
          mb[i] = 6'($urandom);
          r = $urandom_range(0, 7);
          mop[i] = (r < 3) ? 2'b00 : (r < 6) ? 2'b11 : (r == 6) ? 2'b01 : 2'b10;
        end
      end
      req_valid = {v[1], v[0]};
      req_a     = {ma[1], ma[0]};
      req_b     = {mb[1], mb[0]};
      req_op    = {mop[1], mop[0]};
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_rdy = 2'b00;
      if (!m_busy) begin
        if (v[0] && v[1]) exp_rdy = m_ptr ? 2'b01 : 2'b10;
        else if (v[0])    exp_rdy = 2'b01;
        else if (v[1])    exp_rdy = 2'b10;
      end
      check("rnd_req_ready", req_ready, exp_rdy);
      if (m_busy) begin
        if (exp_valid && rsp_ready) m_busy = 1'b0;
      end else if (exp_rdy != 2'b00) begin
        int w;
        w      = exp_rdy[1] ? 1 : 0;
        m_ptr  = (w == 1);
        m_id   = (w == 1);
        m_busy = 1'b1;
        if (mop[w] == 2'b00) begin
          m_res = longint'(ma[w]) + longint'(mb[w]);
          m_err = 1'b0;
          m_due = cyc + 2;
        end else if (mop[w] == 2'b11) begin
          m_res = longint'(ma[w]) * longint'(mb[w]);
          m_err = 1'b0;
          m_due = cyc + W + 1;
        end else begin
          m_res = 0;
          m_err = 1'b1;
          m_due = cyc + 1;
        end
        v[w] = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
